// File: rtl/seg_pkg.sv
// seg_pkg: font table, blanked-segment code and port-width helper shared by seg_scan_mux.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // a..g, active-low; entry 0 sits in the least significant slice
  localparam logic [15:0][6:0] SEG_FONT = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,  // F E D C
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,  // B A 9 8
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,  // 7 6 5 4
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001   // 3 2 1 0
  };

  function automatic int unsigned cw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_hex_font.sv
// seg_hex_font: combinational hex nibble to active-low a..g segment decoder.
module seg_hex_font
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb seg = SEG_FONT[nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed 7-segment scan driver with tear-free shadow frame loading.
// Optional leading-zero blanking is built when SEG_LZB_EN is defined.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int CHANNELS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic [cw(CHANNELS)-1:0]      ch_sel,
  input  logic [CHANNELS*DIGITS*4-1:0] data_in,
  input  logic [CHANNELS*DIGITS-1:0]   blank_mask,
  input  logic [CHANNELS*DIGITS-1:0]   dp_mask,
  input  logic                         disp_en,
  input  logic                         upd_req,
  output logic                         upd_ack,
  output logic                         frame_tick,
  output logic [DIGITS-1:0]            seg_cs,
  output logic [7:0]                   seg_db
);

  localparam int CW = cw(CHANNELS);
  localparam int PW = cw(REFRESH_DIV);
  localparam int DW = cw(DIGITS);
  localparam logic [PW-1:0] PC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DI_LAST = DW'(DIGITS - 1);

  logic [PW-1:0]          pc_q, pc_d;
  logic [DW-1:0]          di_q, di_d;
  logic [DIGITS-1:0][3:0] nib_q, nib_d;
  logic [DIGITS-1:0]      blank_q, blank_d;
  logic [DIGITS-1:0]      dp_q, dp_d;
  logic                   ack_q, ack_d;
  logic [DIGITS-1:0]      cs_q, cs_d;
  logic [7:0]             db_q, db_d;

  logic       slot_tick, boundary, lzb;
  logic [3:0] cur_nib;
  logic [6:0] font_seg;

  always_comb begin
    slot_tick = (pc_q == PC_LAST);
    boundary  = slot_tick && (di_q == '0);
    pc_d      = slot_tick ? '0 : pc_q + 1'b1;
    di_d      = di_q;
    if (slot_tick) di_d = (di_q == '0) ? DI_LAST : di_q - 1'b1;
  end

  // Shadow only changes on the frame boundary, so a frame never mixes old and new data
  always_comb begin
    nib_d   = nib_q;
    blank_d = blank_q;
    dp_d    = dp_q;
    ack_d   = 1'b0;
    if (boundary && upd_req) begin
      ack_d   = 1'b1;
      nib_d   = '0;
      blank_d = '1;
      dp_d    = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (ch_sel == CW'(c)) begin
          nib_d   = data_in[c*DIGITS*4 +: DIGITS*4];
          blank_d = blank_mask[c*DIGITS +: DIGITS];
          dp_d    = dp_mask[c*DIGITS +: DIGITS];
        end
      end
    end
  end

  always_comb cur_nib = nib_q[di_q];

  seg_hex_font u_font (
    .nibble (cur_nib),
    .seg    (font_seg)
  );

  // LZB clears only a..g: the digit stays enabled so its dp can still light
  always_comb begin
    lzb = 1'b0;
`ifdef SEG_LZB_EN
    if (di_q != '0) begin
      lzb = 1'b1;
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (d >= 32'(di_q) && nib_q[d] != 4'h0) lzb = 1'b0;
      end
    end
`endif
    cs_d = '1;
    db_d = SEG_OFF;
    if (int'(pc_q) >= GUARD && disp_en && !blank_q[di_q]) begin
      cs_d = ~(DIGITS'(1) << di_q);
      db_d = {(lzb ? 7'h7F : font_seg), ~dp_q[di_q]};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pc_q    <= '0;
      di_q    <= DI_LAST;
      nib_q   <= '0;
      blank_q <= '1;
      dp_q    <= '0;
      ack_q   <= 1'b0;
      cs_q    <= '1;
      db_q    <= SEG_OFF;
    end else begin
      pc_q    <= pc_d;
      di_q    <= di_d;
      nib_q   <= nib_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
      ack_q   <= ack_d;
      cs_q    <= cs_d;
      db_q    <= db_d;
    end
  end

  assign upd_ack    = ack_q;
  assign frame_tick = boundary;
  assign seg_cs     = cs_q;
  assign seg_db     = db_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: randomized self-checking bench for seg_scan_mux against a cycle-count reference model.
// Build with SEG_LZB_EN defined to check the leading-zero-blanking variant.
module tb_seg_scan_mux;

  localparam int DIGITS      = 4;
  // three channels so that ch_sel = 3 is a representable out-of-range select
  localparam int CHANNELS    = 3;
  localparam int REFRESH_DIV = 4;
  localparam int GUARD       = 1;
  localparam int FRAME       = DIGITS * REFRESH_DIV;

  logic                         clk_in = 1'b0;
  logic                         rst = 1'b1;
  logic [1:0]                   ch_sel = '0;
  logic [CHANNELS*DIGITS*4-1:0] data_in = '0;
  logic [CHANNELS*DIGITS-1:0]   blank_mask = '0;
  logic [CHANNELS*DIGITS-1:0]   dp_mask = '0;
  logic                         disp_en = 1'b1;
  logic                         upd_req = 1'b0;
  logic                         upd_ack, frame_tick;
  logic [DIGITS-1:0]            seg_cs;
  logic [7:0]                   seg_db;

  int checks = 0;
  int failures = 0;

  seg_scan_mux #(
    .DIGITS      (DIGITS),
    .CHANNELS    (CHANNELS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .ch_sel     (ch_sel),
    .data_in    (data_in),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .disp_en    (disp_en),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .frame_tick (frame_tick),
    .seg_cs     (seg_cs),
    .seg_db     (seg_db)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: cycle count since reset plus the displayed frame contents
  int   n = 0;
  int   sh_nib[DIGITS];
  bit   sh_blank[DIGITS];
  bit   sh_dp[DIGITS];
  bit   lzb_on;
  logic [3:0] exp_cs;
  logic [7:0] exp_db;
  logic exp_ack, exp_tick, tick_seen;
  logic [6:0] font_tab[16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Capture of the frame following an acknowledged load (index 0 = ack cycle)
  logic [3:0] obs_cs[FRAME+2], e_cs[FRAME+2];
  logic [7:0] obs_db[FRAME+2], e_db[FRAME+2];
  logic       obs_ack[FRAME+2], e_ack[FRAME+2];
  logic       obs_tick0;
  bit         got_ack;

  // Advance one clock: predict outputs from the pre-edge model state, then update it
  task automatic cycle();
    int pc, di, ch;
    bit bnd, lz;
    pc  = n % REFRESH_DIV;
    di  = DIGITS - 1 - (n / REFRESH_DIV) % DIGITS;
    bnd = (n % FRAME) == FRAME - 1;
    exp_tick  = bnd;
    tick_seen = frame_tick;
    if (rst) begin
      exp_cs  = 4'hF;
      exp_db  = 8'hFF;
      exp_ack = 1'b0;
      n = 0;
      for (int d = 0; d < DIGITS; d++) begin
        sh_nib[d] = 0; sh_blank[d] = 1'b1; sh_dp[d] = 1'b0;
      end
    end else begin
      lz = 1'b0;
      if (lzb_on && di > 0) begin
        lz = 1'b1;
        for (int d = di; d < DIGITS; d++) if (sh_nib[d] != 0) lz = 1'b0;
      end
      if (pc < GUARD || !disp_en || sh_blank[di]) begin
        exp_cs = 4'hF;
        exp_db = 8'hFF;
      end else begin
        exp_cs = ~(4'b0001 << di);
        exp_db = {(lz ? 7'h7F : font_tab[sh_nib[di]]), !sh_dp[di]};
      end
      exp_ack = bnd && upd_req;
      if (exp_ack) begin
        ch = ch_sel;
        for (int d = 0; d < DIGITS; d++) begin
          if (ch < CHANNELS) begin
            sh_nib[d]   = data_in[(ch*DIGITS+d)*4 +: 4];
            sh_blank[d] = blank_mask[ch*DIGITS+d];
            sh_dp[d]    = dp_mask[ch*DIGITS+d];
          end else begin
            sh_nib[d] = 0; sh_blank[d] = 1'b1; sh_dp[d] = 1'b0;
          end
        end
      end
      n++;
    end
    @(posedge clk_in);
    #1;
  endtask

  // Request a load of channel ch and record outputs for the frame after the ack
  task automatic load_frame(input int ch, input logic [15:0] nibs,
                            input logic [3:0] bm, input logic [3:0] dm);
    int k;
    ch_sel = 2'(ch);
    if (ch < CHANNELS) begin
      data_in[ch*16 +: 16]  = nibs;
      blank_mask[ch*4 +: 4] = bm;
      dp_mask[ch*4 +: 4]    = dm;
    end
    upd_req = 1'b1;
    got_ack = 1'b0;
    k = -1;
    for (int i = 0; i < 4*FRAME && k < FRAME + 1; i++) begin
      cycle();
      if (k >= 0) k++;
      else if (upd_ack === 1'b1) begin
        k = 0; upd_req = 1'b0; got_ack = 1'b1; obs_tick0 = tick_seen;
      end
      if (k >= 0) begin
        obs_cs[k] = seg_cs; obs_db[k] = seg_db; obs_ack[k] = upd_ack;
        e_cs[k] = exp_cs;   e_db[k] = exp_db;   e_ack[k] = exp_ack;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    if (seg_cs !== 4'hF) begin failures++; $display("FAIL reset_cs got %b exp 1111", seg_cs); end
    checks++;
    if (seg_db !== 8'hFF) begin failures++; $display("FAIL reset_db got %h exp ff", seg_db); end
    checks++;
    if (upd_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b exp 0", upd_ack); end
    checks++;
    rst = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      cycle();
      if ({seg_cs, seg_db, upd_ack, tick_seen} !== {exp_cs, exp_db, exp_ack, exp_tick}) begin
        failures++;
        $display("FAIL reset_frame cyc %0d got cs=%b db=%b ack=%b tick=%b exp cs=%b db=%b ack=%b tick=%b",
                 i, seg_cs, seg_db, upd_ack, tick_seen, exp_cs, exp_db, exp_ack, exp_tick);
      end
      checks++;
    end
  endtask

  task automatic test_update();
    data_in[0 +: 16]  = 16'($urandom);
    data_in[32 +: 16] = 16'($urandom);
    load_frame(1, 16'h12A0, 4'b0000, 4'b0000);
    if (!got_ack) begin failures++; $display("FAIL update_ack_timeout got none exp ack"); end
    checks++;
    if (got_ack) begin
      if (obs_tick0 !== 1'b1) begin failures++; $display("FAIL update_tick_before_ack got %b exp 1", obs_tick0); end
      checks++;
      for (int k = 0; k <= FRAME + 1; k++) begin
        if ({obs_cs[k], obs_db[k], obs_ack[k]} !== {e_cs[k], e_db[k], e_ack[k]}) begin
          failures++;
          $display("FAIL update_frame k=%0d got cs=%b db=%b ack=%b exp cs=%b db=%b ack=%b",
                   k, obs_cs[k], obs_db[k], obs_ack[k], e_cs[k], e_db[k], e_ack[k]);
        end
        checks++;
      end
      if ({obs_cs[2], obs_db[2]} !== {4'b0111, 8'b10011111}) begin
        failures++; $display("FAIL update_digit3 got cs=%b db=%b exp cs=0111 db=10011111", obs_cs[2], obs_db[2]);
      end
      checks++;
      if (obs_db[10] !== 8'b00010001) begin
        failures++; $display("FAIL update_digit1 got db=%b exp 00010001", obs_db[10]);
      end
      checks++;
    end
  endtask

  task automatic test_lzb();
    logic [7:0] hi_exp;
    hi_exp = lzb_on ? 8'hFF : 8'b00000011;
    load_frame(1, 16'h0050, 4'b0000, 4'b0000);
    if (!got_ack) begin failures++; $display("FAIL lzb_ack_timeout got none exp ack"); end
    checks++;
    if (got_ack) begin
      if (obs_db[2] !== hi_exp) begin failures++; $display("FAIL lzb_digit3 got %b exp %b", obs_db[2], hi_exp); end
      checks++;
      if (obs_db[6] !== hi_exp) begin failures++; $display("FAIL lzb_digit2 got %b exp %b", obs_db[6], hi_exp); end
      checks++;
      if (obs_db[10] !== 8'b01001001) begin failures++; $display("FAIL lzb_digit1 got %b exp 01001001", obs_db[10]); end
      checks++;
      if (obs_db[14] !== 8'b00000011) begin failures++; $display("FAIL lzb_digit0 got %b exp 00000011", obs_db[14]); end
      checks++;
      if (obs_cs[6] !== 4'b1011) begin failures++; $display("FAIL lzb_cs2 got %b exp 1011", obs_cs[6]); end
      checks++;
    end
  endtask

  task automatic test_masks();
    load_frame(1, 16'h12A0, 4'b1000, 4'b0010);
    if (!got_ack) begin failures++; $display("FAIL masks_ack_timeout got none exp ack"); end
    checks++;
    if (got_ack) begin
      if ({obs_cs[2], obs_db[2]} !== {4'hF, 8'hFF}) begin
        failures++; $display("FAIL masks_blank3 got cs=%b db=%b exp cs=1111 db=ff", obs_cs[2], obs_db[2]);
      end
      checks++;
      if (obs_db[10] !== 8'b00010000) begin failures++; $display("FAIL masks_dp1 got %b exp 00010000", obs_db[10]); end
      checks++;
      for (int s = 0; s < DIGITS; s++) begin
        if (obs_cs[1 + s*REFRESH_DIV] !== 4'hF) begin
          failures++; $display("FAIL masks_guard slot %0d got %b exp 1111", s, obs_cs[1 + s*REFRESH_DIV]);
        end
        checks++;
      end
    end
  endtask

  task automatic test_cancel();
    int acks;
    ch_sel = 2'd0;
    data_in[0 +: 16] = 16'($urandom);
    dp_mask[0 +: 4]  = 4'($urandom);
    upd_req = 1'b1;
    for (int i = 0; i < 2*FRAME && (n % FRAME) != FRAME - 3; i++) begin
      cycle();
      if ({seg_cs, seg_db, upd_ack, tick_seen} !== {exp_cs, exp_db, exp_ack, exp_tick}) begin
        failures++; $display("FAIL cancel_pre cyc %0d got cs=%b db=%b ack=%b exp cs=%b db=%b ack=%b",
                             i, seg_cs, seg_db, upd_ack, exp_cs, exp_db, exp_ack);
      end
      checks++;
    end
    upd_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 2*FRAME; i++) begin
      cycle();
      if (upd_ack === 1'b1) acks++;
      if ({seg_cs, seg_db, upd_ack, tick_seen} !== {exp_cs, exp_db, exp_ack, exp_tick}) begin
        failures++; $display("FAIL cancel_hold cyc %0d got cs=%b db=%b ack=%b exp cs=%b db=%b ack=%b",
                             i, seg_cs, seg_db, upd_ack, exp_cs, exp_db, exp_ack);
      end
      checks++;
    end
    if (acks != 0) begin failures++; $display("FAIL cancel_acks got %0d exp 0", acks); end
    checks++;
    load_frame(3, 16'h0000, 4'b0000, 4'b0000);
    if (!got_ack) begin failures++; $display("FAIL invalid_ack_timeout got none exp ack"); end
    checks++;
    if (got_ack) begin
      for (int k = 1; k <= FRAME + 1; k++) begin
        if ({obs_cs[k], obs_db[k]} !== {4'hF, 8'hFF}) begin
          failures++; $display("FAIL invalid_blank k=%0d got cs=%b db=%b exp cs=1111 db=ff", k, obs_cs[k], obs_db[k]);
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    ch_sel = 2'd2;
    data_in[32 +: 16] = 16'($urandom);
    upd_req = 1'b1;
    for (int i = 0; i < 2*FRAME && (n % FRAME) != 7; i++) cycle();
    rst = 1'b1;
    cycle();
    if ({seg_cs, seg_db, upd_ack} !== {4'hF, 8'hFF, 1'b0}) begin
      failures++; $display("FAIL midreset_outputs got cs=%b db=%b ack=%b exp cs=1111 db=ff ack=0",
                           seg_cs, seg_db, upd_ack);
    end
    checks++;
    rst = 1'b0;
    upd_req = 1'b0;
    acks = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      cycle();
      if (upd_ack === 1'b1) acks++;
      if ({seg_cs, seg_db, upd_ack, tick_seen} !== {exp_cs, exp_db, exp_ack, exp_tick}) begin
        failures++; $display("FAIL midreset_after cyc %0d got cs=%b db=%b ack=%b tick=%b exp cs=%b db=%b ack=%b tick=%b",
                             i, seg_cs, seg_db, upd_ack, tick_seen, exp_cs, exp_db, exp_ack, exp_tick);
      end
      checks++;
    end
    if (acks != 0) begin failures++; $display("FAIL midreset_acks got %0d exp 0", acks); end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        data_in    = {$urandom, $urandom};
        blank_mask = 12'($urandom) & 12'($urandom);
        dp_mask    = 12'($urandom);
      end
      if ($urandom_range(9) == 0) disp_en = ($urandom_range(3) != 0);
      if ($urandom_range(11) == 0) begin
        upd_req = ~upd_req;
        ch_sel  = 2'($urandom_range(3));
      end
      cycle();
      if ({seg_cs, seg_db, upd_ack, tick_seen} !== {exp_cs, exp_db, exp_ack, exp_tick}) begin
        failures++; $display("FAIL random cyc %0d got cs=%b db=%b ack=%b tick=%b exp cs=%b db=%b ack=%b tick=%b",
                             i, seg_cs, seg_db, upd_ack, tick_seen, exp_cs, exp_db, exp_ack, exp_tick);
      end
      checks++;
    end
    upd_req = 1'b0;
    disp_en = 1'b1;
  endtask

  initial begin
`ifdef SEG_LZB_EN
    lzb_on = 1'b1;
`else
    lzb_on = 1'b0;
`endif
    test_reset();
    test_update();
    test_lzb();
    test_masks();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
